// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I constants for the multi-cycle control path:
//               opcodes, mux-select encodings, instruction classes and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;

    // Immediate generator format select
    localparam logic [2:0] c_imm_i   = 3'b000;
    localparam logic [2:0] c_imm_s   = 3'b001;
    localparam logic [2:0] c_imm_b   = 3'b010;
    localparam logic [2:0] c_imm_u   = 3'b011;
    localparam logic [2:0] c_imm_j   = 3'b100;
    localparam logic [2:0] c_imm_inv = 3'b111;

    // PC source select
    localparam logic [1:0] c_pc_plus4 = 2'b00;
    localparam logic [1:0] c_pc_alu   = 2'b01;
    localparam logic [1:0] c_pc_jalr  = 2'b10;

    // Register-file write-back source select
    localparam logic [1:0] c_wb_alu  = 2'b00;
    localparam logic [1:0] c_wb_mem  = 2'b01;
    localparam logic [1:0] c_wb_pc4  = 2'b10;

    // ALU operation select
    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_funct = 2'b01;
    localparam logic [1:0] c_alu_passb = 2'b10;

    // Instruction classes produced by the opcode classifier
    typedef enum logic [3:0] {
        CLS_LOAD    = 4'd0,
        CLS_STORE   = 4'd1,
        CLS_BRANCH  = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_AUIPC   = 4'd6,
        CLS_OPIMM   = 4'd7,
        CLS_OP      = 4'd8,
        CLS_ILLEGAL = 4'd9
    } inst_class_t;

    // Controller state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Combinational opcode classifier. Maps inst[6:0] to an
//               instruction class and immediate format, flagging any opcode
//               outside the supported RV32I set as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import riscv_pkg::*;
(
    input  logic [31:0]  i_inst,
    output inst_class_t  o_class,
    output logic [2:0]   o_imm_sel,
    output logic         o_illegal
);

    // Opcode lookup; unknown opcodes get the invalid immediate code
    always_comb begin
        o_class   = CLS_ILLEGAL;
        o_imm_sel = c_imm_inv;
        o_illegal = 1'b0;
        case (i_inst[6:0])
            c_opc_load:   begin o_class = CLS_LOAD;   o_imm_sel = c_imm_i; end
            c_opc_store:  begin o_class = CLS_STORE;  o_imm_sel = c_imm_s; end
            c_opc_branch: begin o_class = CLS_BRANCH; o_imm_sel = c_imm_b; end
            c_opc_jal:    begin o_class = CLS_JAL;    o_imm_sel = c_imm_j; end
            c_opc_jalr:   begin o_class = CLS_JALR;   o_imm_sel = c_imm_i; end
            c_opc_lui:    begin o_class = CLS_LUI;    o_imm_sel = c_imm_u; end
            c_opc_auipc:  begin o_class = CLS_AUIPC;  o_imm_sel = c_imm_u; end
            c_opc_opimm:  begin o_class = CLS_OPIMM;  o_imm_sel = c_imm_i; end
            // R-type has no immediate; I keeps the generator quiet
            c_opc_op:     begin o_class = CLS_OP;     o_imm_sel = c_imm_i; end
            default:      o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle RV32I control FSM. Sequences fetch, decode,
//               execute, memory and write-back over a single-port memory
//               with a req/ready handshake and an optional wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import riscv_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int WAIT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        a_sel,
    output logic        b_sel,
    output logic [1:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        halted,
    output logic        bus_err
);

    localparam logic [WAIT_W-1:0] c_wait_limit = WAIT_W'(WAIT_LIMIT);
    localparam bit                c_timeout_en = (WAIT_LIMIT != 0);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_bus_err;

    inst_class_t        w_class;
    logic [2:0]         w_imm_sel;
    logic               w_illegal;
    logic               w_timeout;
    logic [WAIT_W-1:0]  w_cnt_inc;

    mc_decode u_decode (
        .i_inst    (inst),
        .o_class   (w_class),
        .o_imm_sel (w_imm_sel),
        .o_illegal (w_illegal)
    );

    // Timeout fires only when the budget is spent and ready is still low,
    // so a ready arriving on the last allowed cycle completes normally
    assign w_timeout = c_timeout_en && (r_wait_cnt == c_wait_limit) && !mem_ready;
    // Saturate so an unlimited wait never wraps back through the limit
    assign w_cnt_inc = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + 1'b1;
    assign bus_err   = r_bus_err;

    // State sequencing, wait counter and sticky bus error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_wait_cnt <= '0;
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_state    <= ST_DECODE;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= ST_HALT;
                        r_wait_cnt <= '0;
                        r_bus_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                ST_DECODE: begin
                    r_state    <= w_illegal ? ST_HALT : ST_EXEC;
                    r_wait_cnt <= '0;
                end
                ST_EXEC: begin
                    r_wait_cnt <= '0;
                    case (w_class)
                        CLS_LOAD, CLS_STORE:           r_state <= ST_MEM;
                        CLS_BRANCH, CLS_JAL, CLS_JALR: r_state <= ST_FETCH;
                        CLS_ILLEGAL:                   r_state <= ST_HALT;
                        default:                       r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_state    <= (w_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= ST_HALT;
                        r_wait_cnt <= '0;
                        r_bus_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                ST_WB: begin
                    r_state    <= ST_FETCH;
                    r_wait_cnt <= '0;
                end
                ST_HALT: begin
                    r_state    <= ST_HALT;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Datapath strobes decoded from the current state and instruction
    always_comb begin
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = c_pc_plus4;
        imm_sel      = c_imm_i;
        a_sel        = 1'b0;
        b_sel        = 1'b0;
        alu_op       = c_alu_add;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = c_wb_alu;
        retire       = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            ST_DECODE: begin
                imm_sel = w_imm_sel;
            end
            ST_EXEC: begin
                imm_sel = w_imm_sel;
                case (w_class)
                    CLS_OP: begin
                        alu_op = c_alu_funct;
                    end
                    CLS_OPIMM: begin
                        b_sel  = 1'b1;
                        alu_op = c_alu_funct;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        b_sel = 1'b1;
                    end
                    CLS_AUIPC: begin
                        a_sel = 1'b1;
                        b_sel = 1'b1;
                    end
                    CLS_LUI: begin
                        b_sel  = 1'b1;
                        alu_op = c_alu_passb;
                    end
                    CLS_BRANCH: begin
                        a_sel    = 1'b1;
                        b_sel    = 1'b1;
                        pc_write = 1'b1;
                        pc_sel   = br_taken ? c_pc_alu : c_pc_plus4;
                        retire   = 1'b1;
                    end
                    CLS_JAL, CLS_JALR: begin
                        a_sel     = (w_class == CLS_JAL);
                        b_sel     = 1'b1;
                        pc_write  = 1'b1;
                        pc_sel    = (w_class == CLS_JAL) ? c_pc_alu : c_pc_jalr;
                        reg_write = 1'b1;
                        wb_sel    = c_wb_pc4;
                        retire    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                imm_sel      = w_imm_sel;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (w_class == CLS_STORE);
                if (mem_ready && (w_class == CLS_STORE)) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
            end
            ST_WB: begin
                imm_sel   = w_imm_sel;
                reg_write = 1'b1;
                wb_sel    = (w_class == CLS_LOAD) ? c_wb_mem : c_wb_alu;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            ST_HALT: begin
                imm_sel = c_imm_inv;
                halted  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
